ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320: active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240: active lines per frame.
REQ-003 SHALL have port clk, input, 1: camera pixel clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port capture_en, input, 1: allows capture to start at the next frame boundary.
REQ-006 SHALL have port vsync, input, 1: camera frame sync; high marks the inter-frame gap.
REQ-007 SHALL have port href, input, 1: camera line valid.
REQ-008 SHALL have port cam_data, input, 8: camera byte; high byte first, then low byte of RGB565.
REQ-009 SHALL have port we_out, output, 1: one-cycle pixel write strobe to the downstream filter's we_in.
REQ-010 SHALL have port wAddr_out, output, 17: pixel address, row*IMG_WIDTH+col.
REQ-011 SHALL have port wData_out, output, 16: RGB565 pixel ({R5,G6,B5}).
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each captured frame.
REQ-013 SHALL have port frame_err, output, 1: valid together with frame_done; high if the frame geometry was wrong.

Function
REQ-014 SHALL register vsync, href and cam_data once; all edge detection uses the registered copies and their previous values.
REQ-015 SHALL implement FSM states: WAIT_VS_HIGH, WAIT_VS_FALL, ACTIVE.
- WAIT_VS_HIGH -> WAIT_VS_FALL on registered vsync=1.
- WAIT_VS_FALL -> ACTIVE on vsync falling edge while capture_en=1.
- ACTIVE -> WAIT_VS_FALL on vsync rising edge, or -> WAIT_VS_HIGH if capture_en=0 at that edge.
REQ-016 SHALL, in ACTIVE with registered href=1, toggle a byte-phase bit each cycle: phase 0 latches the high byte; phase 1 forms {high, low}.
REQ-017 SHALL drive we_out=1 exactly 2 clk cycles after the rising edge at which the low byte was present on cam_data, with wAddr_out and wData_out valid in that same cycle.
REQ-018 SHALL increment the column per completed pixel, and on the href falling edge SHALL clear the column and phase, increment the row, and add IMG_WIDTH to the row base.
REQ-019 SHALL suppress we_out for col>=IMG_WIDTH or row>=IMG_HEIGHT; wAddr_out SHALL never exceed IMG_WIDTH*IMG_HEIGHT-1.
REQ-020 SHALL discard a dangling high byte when href falls on phase 1, and SHALL flag the line as an error.
REQ-021 SHALL pulse frame_done for one cycle on the vsync rising edge that ends ACTIVE.
REQ-022 SHALL set frame_err with frame_done if any of these occurred during the frame:
- a line with column count != IMG_WIDTH;
- row count != IMG_HEIGHT;
- an odd byte count on any line.
REQ-023 SHALL clear row, column, row base, phase and error flags on entry to ACTIVE.
REQ-024 SHALL ignore capture_en changes inside ACTIVE; the current frame always completes.
REQ-025 SHALL hold wAddr_out and wData_out at their last written values when we_out=0.

Reset
REQ-026 SHALL, while reset=0, force we_out=0, wAddr_out=0, wData_out=0, frame_done=0, frame_err=0, state=WAIT_VS_HIGH, and clear all counters and input registers.
REQ-027 SHALL, after reset is deasserted mid-frame, emit no pixels until a complete vsync high-then-fall sequence is seen.

Structure
REQ-028 SHALL place the IMG_WIDTH/IMG_HEIGHT defaults, the rgb565_t typedef (r[4:0], g[5:0], b[4:0]) and the capture-state enum in a shared package, photo_booth_pkg.
REQ-029 SHALL be a single module with no sub-module; address generation SHALL use adders only, no multiplier.

Verification
REQ-030 SHALL cover: W=8, H=8, capture_en=1, vsync pulse, then 8 lines of 16 bytes carrying pixel (r+c, 2r+c, 3r+c) -> 64 we_out strobes, addresses 0..63 in order, data matching the pattern, then frame_done=1 with frame_err=0.
REQ-031 SHALL cover: bytes 0xF8,0x1F -> wData_out=16'hF81F, with we_out exactly 2 cycles after the 0x1F byte.
REQ-032 SHALL cover: one line carrying 10 pixels -> only 8 writes for that line, that line's addresses correct, frame_err=1 at frame end.
REQ-033 SHALL cover: a line with 15 bytes -> 7 writes for that line, the dangling byte dropped, frame_err=1.
REQ-034 SHALL cover: capture_en=0 before the vsync fall -> zero writes and no frame_done; capture_en dropped mid-frame -> the frame completes, then no further writes.
REQ-035 SHALL cover: reset=0 asserted at row 3 -> all outputs 0 immediately; after release and a new vsync, capture restarts at address 0.

Source files
------------

// File: rtl/photo_booth_pkg.sv
// Shared geometry defaults, pixel type and capture-state encoding for the
// photo booth camera path.
package photo_booth_pkg;

  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_HEIGHT_DEF = 240;
  localparam int ADDR_W         = 17;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    WAIT_VS_HIGH = 2'd0,
    WAIT_VS_FALL = 2'd1,
    ACTIVE       = 2'd2
  } cap_state_t;

endpackage

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: assembles RGB565 pixels from the camera's
// two-byte stream, generates linear frame-buffer addresses with adders only,
// and reports per-frame completion and geometry errors.
module ov7670_capture
  import photo_booth_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  cam_data,
  output logic        we_out,
  output logic [16:0] wAddr_out,
  output logic [15:0] wData_out,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [ADDR_W-1:0] WIDTH_L  = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] HEIGHT_L = ADDR_W'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] ONE_L    = ADDR_W'(1);

  // Input capture stage and previous values for edge detection.
  logic              vs_q, vs_prev_q, hr_q, hr_prev_q;
  logic [7:0]        dat_q;

  // Capture state and frame counters.
  cap_state_t        state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] col_q, col_d, row_q, row_d, base_q, base_d;
  logic              err_q, err_d;

  // Pixel stage (one cycle after the low byte is registered).
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  rgb565_t           pix_data_q, pix_data_d;
  logic              done_q, done_d, ferr_q, ferr_d;

  // Output stage: holds the last written address/data between strobes.
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  rgb565_t           data_q;

  logic vs_rise, vs_fall, hr_fall;
  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hr_fall = ~hr_q & hr_prev_q;

  // Next-state logic for the frame FSM, byte pairing and address counters.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    err_d      = err_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      WAIT_VS_HIGH: begin
        if (vs_q) state_d = WAIT_VS_FALL;
      end
      WAIT_VS_FALL: begin
        if (vs_fall && capture_en) begin
          state_d = ACTIVE;
          phase_d = 1'b0;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
          err_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          done_d  = 1'b1;
          ferr_d  = err_q | (row_q != HEIGHT_L);
          state_d = capture_en ? WAIT_VS_FALL : WAIT_VS_HIGH;
        end else if (hr_q) begin
          if (!phase_q) begin
            hi_d    = dat_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < WIDTH_L && row_q < HEIGHT_L) begin
              pix_we_d   = 1'b1;
              pix_addr_d = base_q + col_q;
              pix_data_d = rgb565_t'({hi_q, dat_q});
            end
            // Saturate one past the width: enough to detect a long line.
            if (col_q <= WIDTH_L) col_d = col_q + ONE_L;
          end
        end else if (hr_fall) begin
          // A pending high byte or wrong pixel count marks the frame bad.
          if (phase_q || col_q != WIDTH_L) err_d = 1'b1;
          col_d   = '0;
          phase_d = 1'b0;
          if (row_q < HEIGHT_L)  base_d = base_q + WIDTH_L;
          if (row_q <= HEIGHT_L) row_d  = row_q + ONE_L;
        end
      end
      default: state_d = WAIT_VS_HIGH;
    endcase
  end

  // State, pipeline and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      hr_q       <= 1'b0;
      hr_prev_q  <= 1'b0;
      dat_q      <= '0;
      state_q    <= WAIT_VS_HIGH;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      err_q      <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vs_q       <= vsync;
      vs_prev_q  <= vs_q;
      hr_q       <= href;
      hr_prev_q  <= hr_q;
      dat_q      <= cam_data;
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      err_q      <= err_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      we_q       <= pix_we_q;
      if (pix_we_q) begin
        addr_q <= pix_addr_q;
        data_q <= pix_data_q;
      end
    end
  end

  assign we_out     = we_q;
  assign wAddr_out  = addr_q;
  assign wData_out  = data_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture: drives whole frames of camera bytes
// and compares every write (address, data, cycle) and frame report against a
// reference built from the frame description.
module tb_ov7670_capture;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        we_out;
  logic [16:0] wAddr_out;
  logic [15:0] wData_out;
  logic        frame_done, frame_err;

  ov7670_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .we_out     (we_out),
    .wAddr_out  (wAddr_out),
    .wData_out  (wData_out),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame description: bytes per line, line lengths, number of lines.
  logic [7:0] lb [0:15][0:31];
  int         ll [0:15];
  int         nl;
  int         lo_cyc [0:15][0:15];

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  got_q[$];
  int   done_n = 0;
  logic last_err = 1'b0;
  int   stray_err = 0;

  // Monitor: record every write strobe and frame report away from the edge.
  always @(negedge clk) begin
    wr_t w;
    if (we_out) begin
      w.addr = int'(wAddr_out);
      w.data = int'(wData_out);
      w.cyc  = cyc;
      got_q.push_back(w);
    end
    if (frame_done) begin
      done_n++;
      last_err = frame_err;
    end else if (frame_err) begin
      stray_err++;
    end
  end

  function automatic void fill_random(input int lines);
    nl = lines;
    for (int r = 0; r < 16; r++) begin
      ll[r] = 2 * W;
      for (int b = 0; b < 32; b++) lb[r][b] = 8'($urandom);
    end
  endfunction

  function automatic void fill_pattern();
    logic [15:0] px;
    nl = H;
    for (int r = 0; r < H; r++) begin
      ll[r] = 2 * W;
      for (int c = 0; c < W; c++) begin
        px = {5'(r + c), 6'(2 * r + c), 5'(3 * r + c)};
        lb[r][2*c]   = px[15:8];
        lb[r][2*c+1] = px[7:0];
      end
    end
  endfunction

  // Drive one frame: sync pulse, lines with random gaps, closing vsync rise.
  task automatic run_frame(input bit en, input int drop_row, input int rst_row, input int rst_byte);
    capture_en = en;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < nl; r++) begin
      if (r == drop_row) capture_en = 1'b0;
      for (int b = 0; b < ll[r]; b++) begin
        if (r == rst_row && b == rst_byte) begin
          #1 reset = 1'b0;
          #1;
          check("rst_mid.we_out", we_out, 0);
          check("rst_mid.wAddr_out", wAddr_out, 0);
          check("rst_mid.wData_out", wData_out, 0);
          check("rst_mid.frame_done", frame_done, 0);
          check("rst_mid.frame_err", frame_err, 0);
          @(negedge clk);
          @(negedge clk);
          reset = 1'b1;
        end
        href = 1'b1;
        cam_data = lb[r][b];
        if (b % 2 == 1) lo_cyc[r][b/2] = cyc + 1;
        @(negedge clk);
      end
      href = 1'b0;
      cam_data = 8'($urandom);
      repeat ($urandom_range(2, 5)) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Reference: expected writes and frame report from the frame description.
  task automatic check_frame(input string name, input bit cap, input int cut_row, input int cut_byte);
    wr_t exp_q[$];
    wr_t e;
    bit  exp_err;
    int  exp_done;
    int  n;
    exp_err = (nl != H);
    for (int r = 0; r < nl; r++)
      if ((ll[r] / 2) != W || (ll[r] % 2) != 0) exp_err = 1'b1;
    if (cap) begin
      for (int r = 0; r < nl && r < H; r++) begin
        if (cut_row >= 0 && r > cut_row) continue;
        for (int p = 0; p < ll[r] / 2 && p < W; p++) begin
          if (cut_row >= 0 && r == cut_row && !(2 * p + 3 < cut_byte)) continue;
          e.addr = r * W + p;
          e.data = int'({lb[r][2*p], lb[r][2*p+1]});
          e.cyc  = lo_cyc[r][p] + 2;
          exp_q.push_back(e);
        end
      end
    end
    check({name, ".n_writes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr[%0d]", name, i), got_q[i].addr, exp_q[i].addr);
      check($sformatf("%s.data[%0d]", name, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s.cycle[%0d]", name, i), got_q[i].cyc, exp_q[i].cyc);
    end
    exp_done = (cap && cut_row < 0) ? 1 : 0;
    check({name, ".done_count"}, done_n, exp_done);
    if (exp_done == 1) begin
      check({name, ".frame_err"}, last_err, exp_err);
      if (exp_q.size() > 0) begin
        check({name, ".hold_we"}, we_out, 0);
        check({name, ".hold_addr"}, wAddr_out, exp_q[exp_q.size()-1].addr);
        check({name, ".hold_data"}, wData_out, exp_q[exp_q.size()-1].data);
      end
    end
    got_q.delete();
    done_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.we_out", we_out, 0);
    check("reset.wAddr_out", wAddr_out, 0);
    check("reset.wData_out", wData_out, 0);
    check("reset.frame_done", frame_done, 0);
    check("reset.frame_err", frame_err, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full pattern frame.
    fill_pattern();
    run_frame(1'b1, -1, -1, 0);
    check_frame("pattern", 1'b1, -1, 0);

    // Known magenta pixel first, timing of the first strobe.
    fill_random(H);
    lb[0][0] = 8'hF8;
    lb[0][1] = 8'h1F;
    run_frame(1'b1, -1, -1, 0);
    check("f81f.data", (got_q.size() > 0) ? got_q[0].data : -1, 64'hF81F);
    check("f81f.cycle", (got_q.size() > 0) ? got_q[0].cyc : -1, lo_cyc[0][0] + 2);
    check_frame("f81f", 1'b1, -1, 0);

    // Line with 10 pixels.
    fill_random(H);
    ll[2] = 20;
    run_frame(1'b1, -1, -1, 0);
    check_frame("long_line", 1'b1, -1, 0);

    // Line with 15 bytes: dangling high byte.
    fill_random(H);
    ll[5] = 15;
    run_frame(1'b1, -1, -1, 0);
    check_frame("odd_line", 1'b1, -1, 0);

    // Too few and too many lines.
    fill_random(H - 1);
    run_frame(1'b1, -1, -1, 0);
    check_frame("short_frame", 1'b1, -1, 0);
    fill_random(H + 1);
    run_frame(1'b1, -1, -1, 0);
    check_frame("tall_frame", 1'b1, -1, 0);

    // Random clean frames.
    for (int k = 0; k < 2; k++) begin
      fill_random(H);
      run_frame(1'b1, -1, -1, 0);
      check_frame($sformatf("random%0d", k), 1'b1, -1, 0);
    end

    // Capture disabled before the vsync fall.
    fill_random(H);
    run_frame(1'b0, -1, -1, 0);
    check_frame("disabled", 1'b0, -1, 0);

    // Capture dropped mid-frame: frame completes, next one is ignored.
    fill_random(H);
    run_frame(1'b1, 3, -1, 0);
    check_frame("drop_mid", 1'b1, -1, 0);
    fill_random(H);
    run_frame(1'b0, -1, -1, 0);
    check_frame("after_drop", 1'b0, -1, 0);

    // Reset during row 3, then a clean restart from address 0.
    fill_random(H);
    run_frame(1'b1, -1, 3, 10);
    check_frame("reset_frame", 1'b1, 3, 10);
    fill_random(H);
    run_frame(1'b1, -1, -1, 0);
    check_frame("restart", 1'b1, -1, 0);

    check("stray_frame_err", stray_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
